// File: rtl/bin2bcd_disp.sv
// Purpose : sequential binary-to-BCD converter (shift-add-3, one bit per clock)
//           with leading-zero blanking enables and saturate-to-nines overflow.
// Ports   : clk/rst_n; start+bin request; busy, done pulse, bcd, digit_en, ovf.
// Latency : busy for BIN_W cycles after start is accepted; done one cycle.
// Backpr. : start is ignored while busy (not queued); held start restarts in
//           the done cycle, giving one conversion every BIN_W+1 cycles.
module bin2bcd_disp #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  ovf
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    // Largest value representable on the display, e.g. 9999 for 4 digits.
    localparam logic [63:0] MAXV = 64'(10 ** DIGITS) - 64'd1;

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t            state_q;
    logic [BIN_W-1:0]  shift_q;
    logic [SW-1:0]     scr_q;
    logic [CW-1:0]     cnt_q;
    logic              ovf_pend_q;
    logic              busy_q;
    logic              done_q;
    logic [SW-1:0]     bcd_q;
    logic [DIGITS-1:0] en_q;
    logic              ovf_q;

    logic [SW-1:0]     adj;
    logic [SW-1:0]     scr_d;
    logic [BIN_W-1:0]  shift_d;
    logic [SW-1:0]     res_bcd_d;
    logic [DIGITS-1:0] en_d;
    logic              any_nz;
    logic              bin_ovf;

    assign bin_ovf = (64'(bin) > MAXV);

    // One double-dabble step: adjust each nibble independently (4-bit add,
    // no inter-nibble carry), then shift {scratch, shift} left by one.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        {scr_d, shift_d} = {adj, shift_q} << 1;
    end

    // Final result and blanking: a digit is lit if it or any more
    // significant digit is non-zero; the units digit is always lit.
    always_comb begin
        res_bcd_d = ovf_pend_q ? {DIGITS{4'h9}} : scr_d;
        en_d      = '0;
        any_nz    = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz  = any_nz | (res_bcd_d[4*i +: 4] != 4'h0);
            en_d[i] = any_nz;
        end
        en_d[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            en_q       <= DIGITS'(1);
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shift_q    <= bin;
                        scr_q      <= '0;
                        cnt_q      <= CW'(BIN_W);
                        ovf_pend_q <= bin_ovf;
                        busy_q     <= 1'b1;
                        state_q    <= S_CONV;
                    end
                end
                S_CONV: begin
                    shift_q <= shift_d;
                    scr_q   <= scr_d;
                    cnt_q   <= cnt_q - CW'(1);
                    // Last bit: the shifted scratch is the finished result.
                    if (cnt_q == CW'(1)) begin
                        bcd_q   <= res_bcd_d;
                        en_q    <= en_d;
                        ovf_q   <= ovf_pend_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign digit_en = en_q;
    assign ovf      = ovf_q;

endmodule
